// File: rtl/regex_stream_ctrl.sv
// regex_stream_ctrl: framed word stream -> bit-serial regex engine sequencer with match statistics.
// Ports: clk/reset (async active-low); s_valid/s_ready/s_data/s_last/anchored stream input;
// eng_flush/eng_ce/eng_i/eng_c drive the engine, eng_o is its registered match output;
// match_pulse/match_count/overflow/found/first_pos/done report results.
// Define REGEX_CTRL_FIRST_POS_EN to build the first-match position capture; otherwise first_pos is 0.
module regex_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int POS_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              anchored,
    output logic              eng_flush,
    output logic              eng_ce,
    output logic              eng_i,
    output logic              eng_c,
    input  logic              eng_o,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              overflow,
    output logic              found,
    output logic [POS_W-1:0]  first_pos,
    output logic              done
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FLUSH = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] TAIL  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              last_q, last_d, anch_q, anch_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [POS_W-1:0]  cnt_q, cnt_d;
    logic              ce_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d, found_q, found_d;
    logic              in_shift, last_bit;

    assign in_shift    = state_q == SHIFT;
    assign last_bit    = bit_q == BW'(DATA_W - 1);
    assign s_ready     = (state_q == IDLE) | (state_q == WAIT) | (in_shift & last_bit & ~last_q);
    assign eng_flush   = state_q == FLUSH;
    assign eng_ce      = eng_flush | in_shift;
    // Anchored streams offer the start token only with stream bit 0.
    assign eng_i       = in_shift & (~anch_q | (cnt_q == '0));
    assign eng_c       = in_shift & shreg_q[DATA_W-1];
    assign done        = state_q == DONE;
    // ce_q marks the cycle after an engine step, when eng_o reflects that step.
    assign match_pulse = ce_q & eng_o;
    assign match_count = count_q;
    assign overflow    = ovf_q;
    assign found       = found_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        anch_d  = anch_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (s_valid) begin
                state_d = FLUSH;
                shreg_d = s_data;
                last_d  = s_last;
                anch_d  = anchored;
            end
            FLUSH: begin
                state_d = SHIFT;
                bit_d   = '0;
                cnt_d   = '0;
            end
            SHIFT: begin
                shreg_d = shreg_q << 1;
                bit_d   = bit_q + 1'b1;
                cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                if (last_bit) begin
                    bit_d = '0;
                    if (last_q) state_d = TAIL;
                    else if (s_valid) begin
                        shreg_d = s_data;
                        last_d  = s_last;
                    end else state_d = WAIT;
                end
            end
            WAIT: if (s_valid) begin
                state_d = SHIFT;
                shreg_d = s_data;
                last_d  = s_last;
            end
            TAIL:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = eng_flush ? '0 : (match_pulse & ~&count_q) ? count_q + 1'b1 : count_q;
        ovf_d   = ~eng_flush & (ovf_q | (match_pulse & &count_q));
        found_d = ~eng_flush & (found_q | match_pulse);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            last_q  <= 1'b0;
            anch_q  <= 1'b0;
            bit_q   <= '0;
            cnt_q   <= '0;
            ce_q    <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
            anch_q  <= anch_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            ce_q    <= in_shift;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            found_q <= found_d;
        end
    end

`ifdef REGEX_CTRL_FIRST_POS_EN
    logic [POS_W-1:0] pos_q, first_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q   <= '0;
            first_q <= '0;
        end else begin
            pos_q   <= eng_flush ? '0 : in_shift ? cnt_q : pos_q;
            first_q <= eng_flush ? '0 : (match_pulse & ~found_q) ? pos_q : first_q;
        end
    end

    assign first_pos = first_q;
`else
    assign first_pos = '0;
`endif
endmodule

// File: tb/tb_regex_stream_ctrl.sv
// tb_regex_stream_ctrl: directed bench for regex_stream_ctrl driving a behavioural (1|0)*1(1|0){20} engine.
module tb_regex_stream_ctrl;
`ifdef REGEX_CTRL_FIRST_POS_EN
    localparam int FP = 20;
`else
    localparam int FP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        anchored = 1'b0;

    logic        s_ready, eng_flush, eng_ce, eng_i, eng_c, eng_o;
    logic        match_pulse, overflow, found, done;
    logic [15:0] match_count, first_pos;

    logic        s_ready4, eng_flush4, eng_ce4, eng_i4, eng_c4, eng_o4;
    logic        match_pulse4, overflow4, found4, done4;
    logic [3:0]  match_count4;
    logic [15:0] first_pos4;

    regex_stream_ctrl dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .anchored(anchored), .eng_flush(eng_flush), .eng_ce(eng_ce),
        .eng_i(eng_i), .eng_c(eng_c), .eng_o(eng_o), .match_pulse(match_pulse),
        .match_count(match_count), .overflow(overflow), .found(found),
        .first_pos(first_pos), .done(done)
    );

    regex_stream_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
        .s_last(s_last), .anchored(anchored), .eng_flush(eng_flush4), .eng_ce(eng_ce4),
        .eng_i(eng_i4), .eng_c(eng_c4), .eng_o(eng_o4), .match_pulse(match_pulse4),
        .match_count(match_count4), .overflow(overflow4), .found(found4),
        .first_pos(first_pos4), .done(done4)
    );

    always #5 clk = ~clk;

    // Engine model: a match ends on bit k when bit k-20 was 1 and a start token had been seen by then.
    logic [19:0] h0, h1;
    logic        st0, st1;
    always @(posedge clk) begin
        if (!reset || eng_flush) begin
            h0 <= '0; st0 <= 1'b0; eng_o <= 1'b0;
        end else if (eng_ce) begin
            h0 <= {h0[18:0], eng_c & (st0 | eng_i)}; st0 <= st0 | eng_i; eng_o <= h0[19];
        end
    end
    always @(posedge clk) begin
        if (!reset || eng_flush4) begin
            h1 <= '0; st1 <= 1'b0; eng_o4 <= 1'b0;
        end else if (eng_ce4) begin
            h1 <= {h1[18:0], eng_c4 & (st1 | eng_i4)}; st1 <= st1 | eng_i4; eng_o4 <= h1[19];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pulses, ce_n, i_n, dones, flush_cyc, first_sh, last_ce, done_cyc, fp_cyc;
    int d_pulses, d_count, d_found, d_first;
    always @(negedge clk) begin
        pulses   <= eng_flush ? 0 : pulses + int'(match_pulse);
        ce_n     <= eng_flush ? 1 : ce_n + int'(eng_ce);
        i_n      <= eng_flush ? 0 : i_n + int'(eng_i);
        dones    <= eng_flush ? 0 : dones + int'(done);
        if (eng_flush) begin flush_cyc <= cyc; first_sh <= -1; end
        if (eng_ce) last_ce <= cyc;
        if (eng_ce && !eng_flush && first_sh < 0) first_sh <= cyc;
        if (match_pulse && pulses == 0) fp_cyc <= cyc;
        if (done) begin
            done_cyc <= cyc; d_pulses <= pulses;
            d_count <= int'(match_count); d_found <= int'(found); d_first <= int'(first_pos);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // gap>0: wait for s_ready with s_valid low, then idle gap cycles before presenting the word.
    task automatic send(input logic [7:0] d, input logic l, input int gap, output int acc);
        if (gap > 0) begin
            for (int g = 0; g < 100 && !s_ready; g++) @(negedge clk);
            repeat (gap) @(negedge clk);
        end
        s_valid = 1'b1; s_data = d; s_last = l;
        for (int g = 0; g < 100 && !s_ready; g++) @(negedge clk);
        chk("accept", s_ready, 1);
        acc = cyc;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int g = 0; g < 300 && !done; g++) @(negedge clk);
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int acc, a2;
        repeat (2) @(negedge clk);
        chk("rst_ready", s_ready, 1);
        chk("rst_outs", {eng_flush, eng_ce, eng_i, eng_c, match_pulse, done, found, overflow}, 0);
        chk("rst_count", match_count, 0);
        chk("rst_first", first_pos, 0);
        reset = 1'b1;
        @(negedge clk);

        // 0x80,0x00,0x00 unanchored, back to back
        send(8'h80, 1'b0, 0, acc);
        send(8'h00, 1'b0, 0, a2);
        send(8'h00, 1'b1, 0, a2);
        wait_done();
        chk("t1_flush_lat", flush_cyc, acc + 1);
        chk("t1_bit0_lat", first_sh, acc + 2);
        chk("t1_pulse_time", fp_cyc, first_sh + 21);
        chk("t1_pulses", pulses, 1);
        chk("t1_count", match_count, 1);
        chk("t1_found", found, 1);
        chk("t1_first", first_pos, FP);
        chk("t1_ovf", overflow, 0);
        chk("t1_done_lat", done_cyc - last_ce, 2);
        chk("t1_dones", dones, 1);
        chk("t1_ce_cycles", ce_n, 25);
        chk("t1_tokens", i_n, 24);

        // same stream with 5-cycle gaps between words
        send(8'h80, 1'b0, 0, acc);
        send(8'h00, 1'b0, 5, a2);
        send(8'h00, 1'b1, 5, a2);
        wait_done();
        chk("t2_ce_cycles", ce_n, 25);
        chk("t2_count", match_count, 1);
        chk("t2_first", first_pos, FP);
        chk("t2_done_lat", done_cyc - last_ce, 2);

        // anchored 0xFF x4
        anchored = 1'b1;
        send(8'hFF, 1'b0, 0, acc);
        anchored = 1'b0;
        send(8'hFF, 1'b0, 0, a2);
        send(8'hFF, 1'b0, 0, a2);
        send(8'hFF, 1'b1, 0, a2);
        wait_done();
        chk("t3_tokens", i_n, 1);
        chk("t3_pulses", pulses, 12);
        chk("t3_count", match_count, 12);
        chk("t3_first", first_pos, FP);
        chk("t3_done_lat", done_cyc - last_ce, 2);

        // 0xFF x8: 44 matches, 4-bit counter saturates
        for (int w = 0; w < 8; w++) send(8'hFF, w == 7, 0, a2);
        wait_done();
        chk("t4_count", match_count, 44);
        chk("t4_ovf", overflow, 0);
        chk("t4_count4", match_count4, 15);
        chk("t4_ovf4", overflow4, 1);

        // 0x00 x3, next stream's first word held valid through TAIL/DONE
        send(8'h00, 1'b0, 0, a2);
        send(8'h00, 1'b0, 0, a2);
        send(8'h00, 1'b1, 0, a2);
        send(8'hFF, 1'b0, 0, acc);
        chk("t5_accept_after_done", acc, done_cyc + 1);
        chk("t5_pulses", d_pulses, 0);
        chk("t5_count", d_count, 0);
        chk("t5_found", d_found, 0);
        chk("t5_first", d_first, 0);

        // abort mid-SHIFT with matches already seen
        send(8'hFF, 1'b0, 0, a2);
        send(8'hFF, 1'b0, 0, a2);
        repeat (6) @(negedge clk);
        chk("t6_found_before", found, 1);
        reset = 1'b0;
        #1;
        chk("t6_ready", s_ready, 1);
        chk("t6_outs", {eng_flush, eng_ce, eng_i, eng_c, match_pulse, done, found, overflow}, 0);
        chk("t6_count", match_count, 0);
        chk("t6_first", first_pos, 0);
        repeat (3) @(negedge clk);
        chk("t6_no_done", dones, 0);
        reset = 1'b1;
        @(negedge clk);
        send(8'h80, 1'b0, 0, acc);
        send(8'h00, 1'b0, 0, a2);
        send(8'h00, 1'b1, 0, a2);
        wait_done();
        chk("t6_count_after", match_count, 1);
        chk("t6_first_after", first_pos, FP);
        chk("t6_dones", dones, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regex_stream_ctrl.md
# regex_stream_ctrl

Sequencing controller for the bit-serial regex match engine (`regex` top: `clk, reset, i, i_c, o`). It accepts a framed stream of DATA_W-bit words over a valid/ready handshake and serializes each word MSB-first onto the engine's character input. It also gates the engine clock enable, drives the start token, and flushes engine state at the start of every stream. From the engine's match output it produces a per-match pulse, a saturating match count, and an end-of-stream summary.

## Interface
- DATA_W, 8: input word width in bits.
- CNT_W, 16: match counter width.
- POS_W, 16: bit-position counter width.

- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  controller accepts a word this cycle.
- s_data  in  DATA_W  input word, serialized MSB first.
- s_last  in  1  word is the final word of the stream.
- anchored  in  1  sampled on the first word of a stream; 1 = start token on bit 0 only.
- eng_flush  out  1  engine state clear; the engine resets on an edge where this is high.
- eng_ce  out  1  engine clock enable; the engine advances only on edges with eng_ce=1.
- eng_i  out  1  engine start token.
- eng_c  out  1  engine character bit.
- eng_o  in  1  engine match output, registered inside the engine.
- match_pulse  out  1  one-cycle pulse per detected match.
- match_count  out  CNT_W  matches in the current or last stream; saturating.
- overflow  out  1  sticky; set when a match occurs while match_count is at its maximum.
- found  out  1  at least one match in the current or last stream.
- first_pos  out  POS_W  0-based bit index of the first match's final bit.
- done  out  1  one-cycle end-of-stream pulse.

## Operation
- States: IDLE, FLUSH, SHIFT, WAIT, TAIL, DONE.
- **IDLE**
  - s_ready=1.
  - On s_valid: load the shift register, latch s_last and anchored, go to FLUSH.
- **FLUSH**
  - eng_flush=1, eng_ce=1, eng_i=0.
  - Clear match_count, overflow, found, first_pos, the position counter, and the bit index.
  - Go to SHIFT.
- **SHIFT**
  - eng_ce=1, eng_c=shreg[DATA_W-1]; shift left.
  - eng_i=1 every SHIFT cycle if anchored=0; eng_i=1 only on stream bit 0 if anchored=1.
  - Position counter increments and saturates at 2^POS_W-1.
  - On bit index DATA_W-1:
    - If the latched last=1: go to TAIL; s_ready=0.
    - Otherwise s_ready=1. If s_valid, load the next word and stay in SHIFT with no bubble. If not, go to WAIT.
- **WAIT**
  - eng_ce=0, eng_i=0, s_ready=1.
  - On s_valid: load the word and latch s_last, go to SHIFT.
- **TAIL**
  - eng_ce=0; samples the final bit's match result.
  - Go to DONE.
- **DONE**
  - done=1; go to IDLE.
- **Match sampling**
  - ce_q is eng_ce registered, excluding FLUSH cycles; pos_q is the position of the bit consumed.
  - In any cycle with ce_q=1 and eng_o=1:
    - match_pulse=1.
    - match_count increments, saturating at 2^CNT_W-1; overflow is set if already at max.
    - If found=0: first_pos←pos_q, found←1.
  - Sampling is uniform across SHIFT, WAIT, and TAIL.
- Summary outputs hold after DONE until the next FLUSH.
- The s_data/s_last words are transferred only on s_valid & s_ready.

## Timing
- Reset (asynchronous, reset=0): state IDLE.
  - s_ready=1.
  - eng_flush, eng_ce, eng_i, eng_c, match_pulse, done, found, overflow all 0.
  - match_count=0, first_pos=0.
- First accept at cycle t: FLUSH at t+1, bit 0 on eng_c at t+2.
- Sustained rate is 1 bit/cycle with back-to-back words; no bubble between words.
- A match for the bit consumed at cycle k shows match_pulse at k+1.
- The last bit consumed at cycle k: TAIL at k+1, done at k+2 with final counts.
- Reset mid-stream aborts immediately; no done is issued. The next stream flushes the engine before use.
- s_valid in TAIL/DONE is not accepted; it is accepted in the following IDLE cycle.

## Configuration
- REGEX_CTRL_FIRST_POS_EN
  - Defined: the first_pos register and its capture logic are present.
  - Undefined: first_pos is constant 0 and no position capture register is built. The position counter remains, for saturation only.

## Test plan
- Reset asserted mid-SHIFT -> all outputs take their reset values immediately; a following stream of 0x80,0x00,0x00 gives match_count=1, first_pos=20.
- Stream 0x80,0x00,0x00(last), unanchored, with the real engine (pattern `(1|0)*1(1|0){20}`) -> single match_pulse for bit 20; done with match_count=1, found=1, first_pos=20.
- Same stream with a 5-cycle s_valid gap between words -> eng_ce=0 during the gap; identical summary.
- 0xFF ×4 (last on 4th) -> 12 pulses, match_count=12, first_pos=20; done exactly 2 cycles after the bit-31 ce cycle.
- CNT_W=4, 0xFF ×8 -> 44 matches; match_count=15, overflow=1.
- Stream of 0x00 ×3 -> found=0, match_count=0, first_pos=0, done pulse once.
